// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-requester byte scheduler feeding a 16x-oversampled UART transmitter
// Each requester owns a small FIFO; messages are granted whole and byte loads are spaced one UART frame apart.
module uart_tx_sched #(
  parameter int SLOT_CYCLES = 162,
  parameter int FIFO_AW     = 2
) (
  input  logic       tx_clk,
  input  logic       reset,
  input  logic [7:0] a_data,
  input  logic       a_last,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [7:0] b_data,
  input  logic       b_last,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [7:0] uart_data,
  output logic       uart_data_valid,
  output logic       active_src,
  output logic       busy
);

  localparam int               DEPTH  = 1 << FIFO_AW;
  localparam int               CW     = $clog2(SLOT_CYCLES);
  localparam logic [FIFO_AW:0] FULL   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [CW-1:0]    RELOAD = CW'(SLOT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t             state, state_nxt;
  logic [1:0]         in_valid, in_last, ready, push, pop, nonempty;
  logic [7:0]         in_data [2];
  logic [8:0]         mem [2][DEPTH];
  logic [FIFO_AW-1:0] wr_ptr [2];
  logic [FIFO_AW-1:0] rd_ptr [2];
  logic [FIFO_AW:0]   count [2];
  logic [FIFO_AW:0]   count_nxt [2];
  logic [CW-1:0]      counter;
  logic               lock, last_src, sel, eligible, do_pop;
  logic [8:0]         head;

  assign in_valid   = {b_valid, a_valid};
  assign in_last    = {b_last, a_last};
  assign in_data[0] = a_data;
  assign in_data[1] = b_data;
  assign a_ready    = ready[0];
  assign b_ready    = ready[1];
  assign push       = in_valid & ready;
  assign nonempty   = {count[1] != '0, count[0] != '0};
  assign busy       = (state != IDLE) || (|nonempty);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      count_nxt[i] = count[i] + (FIFO_AW + 1)'(push[i]) - (FIFO_AW + 1)'(pop[i]);
    end
  end

  // While locked only the message owner may be granted; otherwise round-robin per message.
  always_comb begin
    sel      = 1'b0;
    eligible = 1'b0;
    if (lock) begin
      sel      = last_src;
      eligible = nonempty[last_src];
    end else if (&nonempty) begin
      sel      = ~last_src;
      eligible = 1'b1;
    end else if (nonempty[0]) begin
      sel      = 1'b0;
      eligible = 1'b1;
    end else if (nonempty[1]) begin
      sel      = 1'b1;
      eligible = 1'b1;
    end
  end

  assign head = mem[sel][rd_ptr[sel]];
  assign pop  = do_pop ? (sel ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_nxt = state;
    do_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (eligible) begin
          do_pop    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: state_nxt = HOLD;
      HOLD: begin
        if (counter == '0) begin
          if (eligible) begin
            do_pop    = 1'b1;
            state_nxt = SEND;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      counter         <= '0;
      uart_data_valid <= 1'b0;
      uart_data       <= 8'h00;
      active_src      <= 1'b0;
      last_src        <= 1'b1;
      lock            <= 1'b0;
      ready           <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      state           <= state_nxt;
      uart_data_valid <= (state == SEND);
      if (state == SEND) begin
        counter <= RELOAD;
      end else if (state == HOLD && counter != '0) begin
        counter <= counter - CW'(1);
      end
      if (do_pop) begin
        uart_data  <= head[7:0];
        active_src <= sel;
        last_src   <= sel;
        lock       <= ~head[8];
      end
      for (int i = 0; i < 2; i++) begin
        count[i] <= count_nxt[i];
        ready[i] <= (count_nxt[i] != FULL);
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + FIFO_AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + FIFO_AW'(1);
      end
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge tx_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {in_last[i], in_data[i]};
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - randomized self-checking bench for uart_tx_sched
// A transaction-level model predicts pulse times, data, source, ready and busy from the scheduling rules.
`timescale 1ns/1ps
module tb_uart_tx_sched;

  localparam int S     = 162;
  localparam int DEPTH = 4;

  logic       tx_clk = 1'b0;
  logic       reset  = 1'b0;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       a_last = 1'b0, b_last = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, b_ready;
  logic [7:0] uart_data;
  logic       uart_data_valid, active_src, busy;

  always #5 tx_clk = ~tx_clk;

  uart_tx_sched #(.SLOT_CYCLES(S), .FIFO_AW(2)) dut (
    .tx_clk(tx_clk), .reset(reset),
    .a_data(a_data), .a_last(a_last), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_last(b_last), .b_valid(b_valid), .b_ready(b_ready),
    .uart_data(uart_data), .uart_data_valid(uart_data_valid),
    .active_src(active_src), .busy(busy)
  );

  typedef struct {
    int         at;
    logic [7:0] data;
    logic       src;
  } pulse_t;

  pulse_t     pend[$];
  logic [8:0] qa[$], qb[$];
  int         cyc = 0, last_pop = -100000, n_checks = 0, n_pass = 0, n_pulses = 0;
  logic       lock_m = 1'b0, last_src_m = 1'b1, acc_a = 1'b0, acc_b = 1'b0;
  logic [1:0] rdy_m = 2'b00;
  logic       busy_m = 1'b0, src_m = 1'b0, did_rst = 1'b0;
  logic [7:0] data_m = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, cyc);
  endtask

  // Model of one rising edge: pop decision uses only bytes accepted at earlier edges.
  task automatic model_edge();
    int         e;
    logic       ne0, ne1, sel, elig;
    logic [8:0] h;
    e     = cyc + 1;
    acc_a = a_valid && rdy_m[0];
    acc_b = b_valid && rdy_m[1];
    if (e >= last_pop + S) begin
      ne0  = qa.size() > 0;
      ne1  = qb.size() > 0;
      sel  = 1'b0;
      elig = 1'b0;
      if (lock_m) begin
        sel  = last_src_m;
        elig = sel ? ne1 : ne0;
      end else if (ne0 && ne1) begin
        sel  = !last_src_m;
        elig = 1'b1;
      end else if (ne0 || ne1) begin
        sel  = ne1;
        elig = 1'b1;
      end
      if (elig) begin
        h = sel ? qb.pop_front() : qa.pop_front();
        pend.push_back('{e + 1, h[7:0], sel});
        last_pop   = e;
        last_src_m = sel;
        lock_m     = !h[8];
        data_m     = h[7:0];
        src_m      = sel;
      end
    end
    if (acc_a) qa.push_back({a_last, a_data});
    if (acc_b) qb.push_back({b_last, b_data});
    rdy_m  = {qb.size() < DEPTH, qa.size() < DEPTH};
    busy_m = (qa.size() > 0) || (qb.size() > 0) || (e < last_pop + S);
  endtask

  task automatic do_cycle(input int pa, input int pb, input int pl);
    @(negedge tx_clk);
    if (pend.size() > 0 && pend[0].at == cyc) begin
      check("pulse", uart_data_valid, 1);
      check("pulse_data", uart_data, pend[0].data);
      check("pulse_src", active_src, pend[0].src);
      n_pulses++;
      void'(pend.pop_front());
    end else begin
      check("no_pulse", uart_data_valid, 0);
    end
    check("data_hold", uart_data, data_m);
    check("src_hold", active_src, src_m);
    check("a_ready", a_ready, rdy_m[0]);
    check("b_ready", b_ready, rdy_m[1]);
    check("busy", busy, busy_m);
    if (acc_a) a_valid = 1'b0;
    if (acc_b) b_valid = 1'b0;
    if (!a_valid && $urandom_range(99) < pa) begin
      a_valid = 1'b1;
      a_data  = 8'($urandom);
      a_last  = $urandom_range(99) < pl;
    end
    if (!b_valid && $urandom_range(99) < pb) begin
      b_valid = 1'b1;
      b_data  = 8'($urandom);
      b_last  = $urandom_range(99) < pl;
    end
    model_edge();
    @(posedge tx_clk);
    cyc++;
  endtask

  // Reset is raised mid-cycle so the asynchronous clear is observed before any clock edge.
  task automatic do_reset();
    @(negedge tx_clk);
    #2 reset = 1'b1;
    #1;
    check("rst_valid", uart_data_valid, 0);
    check("rst_data", uart_data, 8'h00);
    check("rst_src", active_src, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_busy", busy, 0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    qa.delete();
    qb.delete();
    pend.delete();
    last_pop   = -100000;
    last_src_m = 1'b1;
    lock_m     = 1'b0;
    rdy_m      = 2'b00;
    busy_m     = 1'b0;
    acc_a      = 1'b0;
    acc_b      = 1'b0;
    data_m     = 8'h00;
    src_m      = 1'b0;
    @(posedge tx_clk);
    cyc++;
    #2 reset = 1'b0;
  endtask

  initial begin
    do_reset();
    do_cycle(100, 100, 100);
    for (int i = 0; i < 400; i++) do_cycle(0, 0, 0);
    for (int i = 0; i < 3000; i++) do_cycle(3, 3, 50);
    for (int i = 0; i < 6000; i++) begin
      if (!did_rst && cyc == last_pop + 40 && qa.size() > 0 && qb.size() > 0) begin
        do_reset();
        did_rst = 1'b1;
      end
      do_cycle(60, 60, 30);
    end
    for (int i = 0; i < 3000; i++) do_cycle(80, 80, 100);
    for (int i = 0; i < 400; i++) do_cycle(0, 0, 0);
    check("hold_reset_done", did_rst, 1);
    check("pulses_seen", n_pulses > 40, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter SLOT_CYCLES, default 162: tx_clk cycles between successive uart_data_valid pulses; legal minimum 161 (10 bits x 16 oversampling + 1).
REQ-002 Parameter FIFO_AW, default 2: per-requester FIFO address width; depth is 2**FIFO_AW entries of 9 bits ({last, data}).
REQ-003 tx_clk  in  1  16x-oversampled UART clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 a_data  in  8  requester A byte.
REQ-006 a_last  in  1  requester A end-of-message marker, qualified by a_valid.
REQ-007 a_valid  in  1  requester A byte offered.
REQ-008 a_ready  out  1  requester A FIFO not full.
REQ-009 b_data, b_last, b_valid, b_ready: requester B equivalents, same widths and directions as A.
REQ-010 uart_data  out  8  byte presented to the UART transmitter.
REQ-011 uart_data_valid  out  1  single-cycle load strobe to the UART transmitter.
REQ-012 active_src  out  1  source of the current or last sent byte (0 = A, 1 = B).
REQ-013 busy  out  1  high in any state other than IDLE, or while either FIFO is non-empty.

Function
REQ-014 Byte accepted into a FIFO on a rising edge where xx_valid && xx_ready; xx_ready = FIFO not full, registered with no combinational path from xx_valid.
REQ-015 Offer while full is not accepted; the requester holds data and valid until ready.
REQ-016 A byte written at edge N is not readable before edge N+1; no same-cycle write-through.
REQ-017 FSM states: IDLE, SEND, HOLD.
REQ-018 IDLE: select a source per REQ-021..023; pop its head into uart_data/last_reg/active_src; go to SEND. Remain in IDLE if no eligible source.
REQ-019 SEND: exactly one cycle with uart_data_valid=1, with uart_data stable; load slot counter with SLOT_CYCLES-2; go to HOLD.
REQ-020 HOLD: decrement the counter. At zero, if an eligible source exists, pop it and go to SEND; otherwise go to IDLE. With continuous backlog, rising edges of uart_data_valid are exactly SLOT_CYCLES apart.
REQ-021 Lock: a popped byte with last=0 locks the grant to its source; only that source is eligible until a byte with last=1 from it is popped. The other FIFO waits even if non-empty; there is no timeout.
REQ-022 When unlocked and both FIFOs are non-empty, grant the source opposite to last_src (round-robin per message). last_src updates on each pop.
REQ-023 When unlocked and only one FIFO is non-empty, grant that FIFO.
REQ-024 Latency: when the FSM is IDLE, unlocked and both FIFOs are empty, a byte accepted at edge N produces uart_data_valid high in the cycle following edge N+2.
REQ-025 uart_data holds its value between pulses; it changes only on a pop.
REQ-026 Simultaneous push and pop on the same FIFO is legal and keeps the count unchanged; pointers wrap modulo depth; full/empty are derived from an FIFO_AW+1-bit count.
REQ-027 SLOT_CYCLES < 161 is out of scope; behaviour is undefined.

Reset
REQ-028 Asserting reset at any time, including in SEND or HOLD, immediately sets: state IDLE, uart_data_valid=0, uart_data=8'h00, active_src=0, last_src=1 (A wins first arbitration), lock cleared, counter=0, both FIFOs empty, a_ready=b_ready=0.
REQ-029 a_ready and b_ready go to 1 on the first rising edge after reset deasserts; a byte interrupted by reset is discarded and never re-sent.

Verification
REQ-030 A sends one byte 0x55 (last=1) while idle -> one uart_data_valid pulse with uart_data=0x55 two edges after acceptance; active_src=0; busy drops after SLOT_CYCLES.
REQ-031 A streams 0x01..0x06 (last only on 0x06) -> FIFO fills, a_ready toggles, six pulses spaced exactly 162 cycles, data in order.
REQ-032 A and B each offer one last=1 byte (0xA0, 0xB0) in the same cycle -> 0xA0 is sent first, then 0xB0 162 cycles later.
REQ-033 A sends 3-byte message 0x11,0x12,0x13(last) while B has 0xBB pending -> B is sent only after 0x13; no interleaving.
REQ-034 Reset pulse 40 cycles into HOLD with both FIFOs holding data -> outputs return to reset values immediately, no further pulses, ready returns 1 one edge after reset release.
REQ-035 Back-to-back messages A, B, A, B with both FIFOs backlogged -> sources strictly alternate per message.
